ahb_mst_arb: RTL and testbench
==============================

# ahb_mst_arb

Two-port arbiter that shares the single simple-AHB master port (Req/Write/Size/Addr/Out/In/Okay handshake, as driven by the UART-to-AHB bridge) between two requesters, e.g. the debug bridge on port 0 and a DMA or CPU-side master on port 1. It selects one requester with round-robin priority, holds the grant until the transfer (or locked burst) completes, and routes completion back only to the granted requester. It sits between the masters and the AHB slave-side interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles granted without Okay (used only with ARB_TIMEOUT_EN), ≥2
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- M0Req / M1Req  in  1  transfer request, held until the Okay cycle
- M0Burst / M1Burst  in  1  lock request: keep grant after the current Okay
- M0Busy / M1Busy  in  1  busy indication, forwarded
- M0Write / M1Write  in  1  1 = write
- M0Size / M1Size  in  3  transfer size
- M0Addr / M1Addr  in  ADDR_W  address
- M0Out / M1Out  in  DATA_W  write data
- M0In / M1In  out  DATA_W  read data (AhbIn broadcast to both ports)
- M0Okay / M1Okay  out  1  completion, granted port only
- M0Gnt / M1Gnt  out  1  registered grant status
- M0Err / M1Err  out  1  timeout pulse (tied 0 without ARB_TIMEOUT_EN)
- AhbReq, AhbBurst, AhbBusy, AhbWrite  out  1  muxed master controls
- AhbSize  out  3; AhbAddr  out  ADDR_W; AhbOut  out  DATA_W
- AhbIn  in  DATA_W; Okay  in  1  slave completion

## Operation
- States: IDLE, GNT0, GNT1 (registered). Round-robin pointer LastGnt (1 bit), reset 1, so port 0 wins the first tie.
- IDLE: no request → stay. One request → GNTx. Both → GNT of port != LastGnt. LastGnt updated on entry to GNTx.
- GNTx: all Ahb* outputs combinationally equal port x inputs; MxOkay = Okay; other port's Okay = 0.
- GNTx exits:
  - Okay and MxBurst = 0 → IDLE.
  - Okay and MxBurst = 1 → stay GNTx (locked).
  - MxReq = 0 and Okay = 0 → IDLE (abandoned/burst end).
- IDLE outputs: AhbReq/Burst/Busy/Write = 0, AhbSize = 3'b010, AhbAddr = 0, AhbOut = 0. Okay in IDLE is ignored; both MxOkay = 0.
- MxGnt = (state == GNTx).
- Reset value of every output: all 0 except AhbSize = 3'b010; M0In/M1In follow AhbIn.
- Reset mid-transfer: immediate IDLE, LastGnt = 1; no Okay/Err is generated.

## Timing
- Request sampled in IDLE at cycle t → MxGnt and AhbReq high at t+1.
- Okay at cycle k → MxOkay at k (zero latency), state IDLE at k+1, next grant at k+2 at the earliest. Requesters drop Req in the Okay cycle combinationally, and AhbReq follows in the same cycle.
- The requester that is not granted sees no effect; its Req is sampled only in IDLE.
- Fairness: with both ports continuously requesting single transfers, grants alternate 0,1,0,1.
- Locked burst: no IDLE gap between beats; rearbitration occurs only after the unlocked Okay.

## Configuration
- ARB_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT+1). It clears on entry to GNTx and on each Okay, and increments each granted cycle without Okay. When count = TIMEOUT−1 and Okay = 0: MxErr high for one cycle, AhbReq forced 0 that cycle, state IDLE next. Okay in the same cycle wins, with no Err.
- ARB_TIMEOUT_EN undefined: no counter; M0Err = M1Err = 0; a grant is held indefinitely while Req is high.

## Test plan
- Reset: RST_N low mid-GNT1 → all outputs 0, AhbSize = 3'b010; first tie after release → M0Gnt at t+1.
- Single port 0 write, Addr = 0x1000_0000, Out = 0xDEADBEEF, Okay after 3 cycles → Ahb* mirrors port 0, M0Okay in the Okay cycle, M1Okay = 0, IDLE next.
- Both ports request continuously for 4 transfers each → grant order 0,1,0,1,… with one IDLE cycle between grants.
- Port 1 locked burst of 4 (Burst = 1 on the first 3 Okays) with port 0 requesting → M1Gnt held for all 4 beats, M0Gnt 2 cycles after the 4th Okay.
- Port 0 read, Okay with AhbIn = 0x12345678 → M0In = 0x12345678 and M0Okay = 1 in the same cycle.
- ARB_TIMEOUT_EN, TIMEOUT = 4, no Okay → M0Err pulse on the 4th granted cycle, IDLE next. Repeat with Okay on that cycle → no Err.

Source files
------------

// File: rtl/ahb_mst_arb.sv
// Round-robin arbiter that shares one simple-AHB master port between two requesters.
// Grant holds through the Okay of a locked burst; ARB_TIMEOUT_EN adds a watchdog that aborts stuck grants.
module ahb_mst_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              M0Req,
  input  logic              M0Burst,
  input  logic              M0Busy,
  input  logic              M0Write,
  input  logic [2:0]        M0Size,
  input  logic [ADDR_W-1:0] M0Addr,
  input  logic [DATA_W-1:0] M0Out,
  output logic [DATA_W-1:0] M0In,
  output logic              M0Okay,
  output logic              M0Gnt,
  output logic              M0Err,
  input  logic              M1Req,
  input  logic              M1Burst,
  input  logic              M1Busy,
  input  logic              M1Write,
  input  logic [2:0]        M1Size,
  input  logic [ADDR_W-1:0] M1Addr,
  input  logic [DATA_W-1:0] M1Out,
  output logic [DATA_W-1:0] M1In,
  output logic              M1Okay,
  output logic              M1Gnt,
  output logic              M1Err,
  output logic              AhbReq,
  output logic              AhbBurst,
  output logic              AhbBusy,
  output logic              AhbWrite,
  output logic [2:0]        AhbSize,
  output logic [ADDR_W-1:0] AhbAddr,
  output logic [DATA_W-1:0] AhbOut,
  input  logic [DATA_W-1:0] AhbIn,
  input  logic              Okay
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  logic [1:0] state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic       granted, sel1, gnt_req, gnt_burst, timeout;

  assign granted   = (state_q == GNT0) || (state_q == GNT1);
  assign sel1      = (state_q == GNT1);
  assign gnt_req   = sel1 ? M1Req   : M0Req;
  assign gnt_burst = sel1 ? M1Burst : M0Burst;

`ifdef ARB_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero while idle, so every new grant starts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!granted || Okay) cnt_d = '0;
    else                  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout = granted && !Okay && (cnt_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        // Port 0 wins a tie only when port 1 was served last.
        if (M0Req && (!M1Req || last_gnt_q)) begin
          state_d    = GNT0;
          last_gnt_d = 1'b0;
        end else if (M1Req) begin
          state_d    = GNT1;
          last_gnt_d = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (Okay) begin
          if (!gnt_burst) state_d = IDLE;
        end else if (!gnt_req || timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  assign AhbReq   = granted && gnt_req && !timeout;
  assign AhbBurst = granted && gnt_burst;
  assign AhbBusy  = granted && (sel1 ? M1Busy  : M0Busy);
  assign AhbWrite = granted && (sel1 ? M1Write : M0Write);
  assign AhbSize  = !granted ? 3'b010 : (sel1 ? M1Size : M0Size);
  assign AhbAddr  = !granted ? '0 : (sel1 ? M1Addr : M0Addr);
  assign AhbOut   = !granted ? '0 : (sel1 ? M1Out  : M0Out);

  assign M0In   = AhbIn;
  assign M1In   = AhbIn;
  assign M0Gnt  = (state_q == GNT0);
  assign M1Gnt  = (state_q == GNT1);
  assign M0Okay = M0Gnt && Okay;
  assign M1Okay = M1Gnt && Okay;
  assign M0Err  = M0Gnt && timeout;
  assign M1Err  = M1Gnt && timeout;

endmodule

// File: tb/tb_ahb_mst_arb.sv
// Directed bench for ahb_mst_arb: reset, single transfer, fairness, locked burst, read data, abandon, timeout.
module tb_ahb_mst_arb;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        M0Req, M0Burst, M0Busy, M0Write, M1Req, M1Burst, M1Busy, M1Write;
  logic [2:0]  M0Size, M1Size, AhbSize;
  logic [31:0] M0Addr, M0Out, M0In, M1Addr, M1Out, M1In, AhbAddr, AhbOut, AhbIn;
  logic        M0Okay, M0Gnt, M0Err, M1Okay, M1Gnt, M1Err;
  logic        AhbReq, AhbBurst, AhbBusy, AhbWrite, Okay;
  int          vectors = 0;
  int          miscompares = 0;

  ahb_mst_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .M0Req(M0Req), .M0Burst(M0Burst), .M0Busy(M0Busy), .M0Write(M0Write), .M0Size(M0Size),
    .M0Addr(M0Addr), .M0Out(M0Out), .M0In(M0In), .M0Okay(M0Okay), .M0Gnt(M0Gnt), .M0Err(M0Err),
    .M1Req(M1Req), .M1Burst(M1Burst), .M1Busy(M1Busy), .M1Write(M1Write), .M1Size(M1Size),
    .M1Addr(M1Addr), .M1Out(M1Out), .M1In(M1In), .M1Okay(M1Okay), .M1Gnt(M1Gnt), .M1Err(M1Err),
    .AhbReq(AhbReq), .AhbBurst(AhbBurst), .AhbBusy(AhbBusy), .AhbWrite(AhbWrite),
    .AhbSize(AhbSize), .AhbAddr(AhbAddr), .AhbOut(AhbOut), .AhbIn(AhbIn), .Okay(Okay)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {AhbReq, AhbBurst, AhbBusy, AhbWrite, M0Okay, M1Okay,
                        M0Gnt, M1Gnt, M0Err, M1Err, AhbSize}, 13'h002);
    chk({tag, "_addr"}, AhbAddr, 0);
    chk({tag, "_out"}, AhbOut, 0);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    M0Req = 0; M0Burst = 0; M0Busy = 0; M0Write = 0; M0Size = 0; M0Addr = 0; M0Out = 0;
    M1Req = 0; M1Burst = 0; M1Busy = 0; M1Write = 0; M1Size = 0; M1Addr = 0; M1Out = 0;
    Okay = 0; AhbIn = 32'hA5A5_5A5A;

    // Reset values
    #3;
    chk_idle("rst");
    chk("rst_m0in", M0In, 32'hA5A5_5A5A);
    #4 RST_N = 1'b1;
    cyc();

    // Grant port 1, then reset in the middle of it
    M1Req = 1; M1Write = 1; M1Size = 3'b001; M1Addr = 32'h2000_0040; M1Out = 32'h0BAD_F00D;
    M1Burst = 1; M1Busy = 1;
    #1 chk("pre_gnt1", M1Gnt, 0);
    cyc();
    chk("gnt1_ctl", {M1Gnt, M0Gnt, AhbReq, AhbWrite, AhbBurst, AhbBusy}, 6'b101111);
    chk("gnt1_addr", AhbAddr, 32'h2000_0040);
    Okay = 1;
    RST_N = 1'b0;
    #1;
    chk_idle("midrst");
    chk("midrst_m1in", M1In, 32'hA5A5_5A5A);
    Okay = 0; M1Burst = 0; M1Busy = 0; M0Req = 1;
    #2 RST_N = 1'b1;
    cyc();
    chk("tie_after_rst", {M0Gnt, M1Gnt}, 2'b10);
    M0Req = 0; M1Req = 0;
    cyc();
    chk("abandon0", {M0Gnt, M1Gnt}, 2'b00);

    // Single port 0 write, Okay on the 4th granted cycle
    M0Req = 1; M0Write = 1; M0Size = 3'b010; M0Addr = 32'h1000_0000; M0Out = 32'hDEAD_BEEF;
    M1Write = 0; M1Size = 3'b000; M1Addr = 32'h3333_3333; M1Out = 32'h4444_4444;
    cyc();
    chk("wr_ctl", {M0Gnt, M1Gnt, AhbReq, AhbWrite, AhbBurst, AhbSize}, 8'b1011_0010);
    chk("wr_addr", AhbAddr, 32'h1000_0000);
    chk("wr_out", AhbOut, 32'hDEAD_BEEF);
    cyc();
    cyc();
    cyc();
    Okay = 1; M0Req = 0;
    #1 chk("wr_okay", {M0Okay, M1Okay, AhbReq}, 3'b100);
    cyc();
    Okay = 0;
    chk("wr_idle", {M0Gnt, AhbReq}, 2'b00);
    chk("wr_idle_addr", AhbAddr, 0);

    // Fairness: both requesting continuously
    RST_N = 1'b0;
    #1 RST_N = 1'b1;
    M0Req = 1; M1Req = 1; M0Write = 0;
    for (int g = 0; g < 8; g++) begin
      cyc();
      chk("rr_gnt", {M0Gnt, M1Gnt}, (g % 2 == 1) ? 2'b01 : 2'b10);
      Okay = 1;
      #1 chk("rr_okay", {M0Okay, M1Okay}, (g % 2 == 1) ? 2'b01 : 2'b10);
      cyc();
      Okay = 0;
      chk("rr_gap", {M0Gnt, M1Gnt}, 2'b00);
    end
    M0Req = 0; M1Req = 0;

    // Locked burst of 4 on port 1 while port 0 waits
    M1Req = 1; M1Burst = 1;
    cyc();
    M0Req = 1;
    for (int b = 0; b < 4; b++) begin
      chk("burst_gnt", {M0Gnt, M1Gnt}, 2'b01);
      M1Burst = (b < 3);
      if (b == 3) M1Req = 0;
      Okay = 1;
      #1 chk("burst_okay", {M0Okay, M1Okay}, 2'b01);
      cyc();
      Okay = 0;
    end
    chk("burst_end_idle", {M0Gnt, M1Gnt}, 2'b00);
    cyc();
    chk("burst_then_m0", {M0Gnt, M1Gnt}, 2'b10);

    // Port 0 read completes with data
    AhbIn = 32'h1234_5678; Okay = 1; M0Req = 0;
    #1;
    chk("rd_m0in", M0In, 32'h1234_5678);
    chk("rd_m1in", M1In, 32'h1234_5678);
    chk("rd_okay", {M0Okay, M1Okay}, 2'b10);
    cyc();
    Okay = 0;

    // Port 1 abandons its request
    M1Req = 1; M1Burst = 0;
    cyc();
    chk("ab_gnt", M1Gnt, 1);
    M1Req = 0;
    cyc();
    chk("ab_idle", M1Gnt, 0);

    M0Req = 1; M0Burst = 0;
    cyc();
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      chk("to_err", {M0Err, M1Err, AhbReq, M0Gnt}, (c == 4) ? 4'b1001 : 4'b0011);
      if (c < 4) cyc();
    end
    cyc();
    chk("to_idle", {M0Gnt, M0Err}, 2'b00);
    cyc();
    cyc();
    cyc();
    cyc();
    Okay = 1; M0Req = 0;
    #1 chk("to_okay_wins", {M0Err, M0Okay}, 2'b01);
    cyc();
    Okay = 0;
    chk("to_okay_idle", M0Gnt, 0);
`else
    repeat (20) cyc();
    chk("hold_gnt", {M0Gnt, M0Err, M1Err, AhbReq}, 4'b1001);
    M0Req = 0;
    cyc();
    chk("hold_release", M0Gnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
